// File: rtl/calc_hex_checker.sv
// calc_hex_checker -- on-chip self-test responder for the 4-bit signed calculator.
//
// Sweeps every op (0..5) x SW (8'h00..8'hFF) combination into the calculator,
// waits SETTLE_CYCLES, decodes the seven-segment displays back to signed values
// and compares them against a 6-bit golden model. Mismatching vectors are
// counted (saturating) and the first failing vector is latched.
//
// Ports:
//   CLOCK_50, RESET_N        clock, async active-low reset
//   START                    one-cycle sweep start (honoured in IDLE/DONE only)
//   KEY[2:0], SW[7:0]        op code / operands {A,B} driven to the calculator
//   HEX7..HEX2, HEX0         calculator displays, active-low {g,f,e,d,c,b,a}
//   BUSY, DONE, PASS         sweep status; PASS qualified by DONE
//   ERR_COUNT[10:0]          failing-vector count, saturates at 2047
//   FAIL_VEC[10:0]           {op,SW} of first failure, 11'h7FF if none
//
// Configuration macro: CALC_CHECK_OPERANDS_EN -- when defined, HEX7/HEX6 must
// also decode to A and HEX5/HEX4 to B on every vector.
`timescale 1ns/1ps
module calc_hex_checker #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        CLOCK_50,
    input  logic        RESET_N,
    input  logic        START,
    output logic [2:0]  KEY,
    output logic [7:0]  SW,
    input  logic [6:0]  HEX7,
    input  logic [6:0]  HEX6,
    input  logic [6:0]  HEX5,
    input  logic [6:0]  HEX4,
    input  logic [6:0]  HEX3,
    input  logic [6:0]  HEX2,
    input  logic [6:0]  HEX0,
    output logic        BUSY,
    output logic        DONE,
    output logic        PASS,
    output logic [10:0] ERR_COUNT,
    output logic [10:0] FAIL_VEC
);

    localparam logic [6:0]  SEG_BLANK  = 7'b1111111;
    localparam logic [6:0]  SEG_MINUS  = 7'b0111111;
    localparam logic [6:0]  SEG_ONE    = 7'b1111001;
    localparam logic [6:0]  SEG_E      = 7'b0000110;
    localparam logic [10:0] LAST_VEC   = 11'd1535;
    localparam logic [10:0] NO_FAIL    = 11'h7FF;
    localparam logic [3:0]  SETTLE_LD  = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_e;

    state_e      state_q;
    logic [10:0] vec_q;
    logic [3:0]  settle_q;
    logic [2:0]  key_q;
    logic [7:0]  sw_q;
    logic        busy_q, done_q, pass_q;
    logic [10:0] err_q, fail_q;

    // {valid, digit}
    function automatic logic [4:0] dec_digit(input logic [6:0] s);
        case (s)
            7'b1000000: return {1'b1, 4'd0};
            7'b1111001: return {1'b1, 4'd1};
            7'b0100100: return {1'b1, 4'd2};
            7'b0110000: return {1'b1, 4'd3};
            7'b0011001: return {1'b1, 4'd4};
            7'b0010010: return {1'b1, 4'd5};
            7'b0000010: return {1'b1, 4'd6};
            7'b1111000: return {1'b1, 4'd7};
            7'b0000000: return {1'b1, 4'd8};
            7'b0010000: return {1'b1, 4'd9};
            default:    return {1'b0, 4'd0};
        endcase
    endfunction

    // {valid, signed 6-bit value}; hi selects sign or the tens digit
    function automatic logic [6:0] dec_pair(input logic [6:0] hi, input logic [6:0] lo);
        logic [4:0] d;
        logic [5:0] mag;
        d   = dec_digit(lo);
        mag = {2'b00, d[3:0]};
        case (hi)
            SEG_BLANK: return {d[4], mag};
            SEG_MINUS: return {d[4], 6'(-mag)};
            SEG_ONE:   return {d[4], 6'(mag + 6'd10)};
            default:   return {1'b0, 6'd0};
        endcase
    endfunction

    // Golden model at 6 bits so overflow is visible as out-of-range.
    logic signed [5:0] a6, b6, r6;
    logic              ovf;
    logic [6:0]        res_dec;
    logic              res_bad, hex0_bad, opnd_bad, mism;

    always_comb begin
        a6 = {{2{sw_q[7]}}, sw_q[7:4]};
        b6 = {{2{sw_q[3]}}, sw_q[3:0]};
        case (key_q)
            3'd0:    r6 = a6 + b6;
            3'd1:    r6 = b6 + a6;
            3'd2:    r6 = a6 - b6;
            3'd3:    r6 = b6 - a6;
            3'd4:    r6 = a6[5] ? -a6 : a6;
            3'd5:    r6 = b6[5] ? -b6 : b6;
            default: r6 = '0;
        endcase
        ovf = (r6 < -6'sd8) || (r6 > 6'sd7);
    end

    always_comb begin
        res_dec  = dec_pair(HEX3, HEX2);
        hex0_bad = ovf ? (HEX0 != SEG_E) : (HEX0 != SEG_BLANK);
        // Result digits are meaningless on overflow, so only checked otherwise.
        res_bad  = !ovf && (!res_dec[6] || (res_dec[5:0] != r6));
    end

`ifdef CALC_CHECK_OPERANDS_EN
    logic [6:0] a_dec, b_dec;
    always_comb begin
        a_dec    = dec_pair(HEX7, HEX6);
        b_dec    = dec_pair(HEX5, HEX4);
        opnd_bad = !a_dec[6] || (a_dec[5:0] != a6) ||
                   !b_dec[6] || (b_dec[5:0] != b6);
    end
`else
    logic unused_hex;
    assign unused_hex = ^{HEX7, HEX6, HEX5, HEX4};
    assign opnd_bad   = 1'b0;
`endif

    assign mism = hex0_bad || res_bad || opnd_bad;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= ST_IDLE;
            vec_q    <= '0;
            settle_q <= '0;
            key_q    <= '0;
            sw_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= '0;
            fail_q   <= NO_FAIL;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (START) begin
                        state_q <= ST_DRIVE;
                        vec_q   <= '0;
                        key_q   <= '0;
                        sw_q    <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                        err_q   <= '0;
                        fail_q  <= NO_FAIL;
                    end
                end
                ST_DRIVE: begin
                    state_q  <= ST_SETTLE;
                    settle_q <= SETTLE_LD;
                end
                ST_SETTLE: begin
                    if (settle_q == 4'd0) state_q <= ST_CHECK;
                    else                  settle_q <= settle_q - 4'd1;
                end
                ST_CHECK: begin
                    if (mism) begin
                        if (err_q != NO_FAIL) err_q <= err_q + 11'd1;
                        if (err_q == '0)      fail_q <= {key_q, sw_q};
                    end
                    if (vec_q == LAST_VEC) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= !mism && (err_q == '0);
                    end else begin
                        state_q <= ST_DRIVE;
                        vec_q   <= vec_q + 11'd1;
                        key_q   <= 3'(vec_q + 11'd1 >> 8);
                        sw_q    <= 8'(vec_q + 11'd1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign KEY       = key_q;
    assign SW        = sw_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign PASS      = pass_q;
    assign ERR_COUNT = err_q;
    assign FAIL_VEC  = fail_q;

endmodule

// File: tb/tb_calc_hex_checker.sv
`timescale 1ns/1ps
module tb_calc_hex_checker;

    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] MINUS = 7'b0111111;
    localparam logic [6:0] SEG_E = 7'b0000110;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  key;
    logic [7:0]  sw;
    logic [6:0]  hex7, hex6, hex5, hex4, hex3, hex2, hex0;
    logic        busy, done, pass;
    logic [10:0] err_count, fail_vec;

    int applied = 0;
    int miscompares = 0;
    int fault = 0;

    always #5 clk = ~clk;

    calc_hex_checker #(.SETTLE_CYCLES(4)) dut (
        .CLOCK_50(clk), .RESET_N(rst_n), .START(start),
        .KEY(key), .SW(sw),
        .HEX7(hex7), .HEX6(hex6), .HEX5(hex5), .HEX4(hex4),
        .HEX3(hex3), .HEX2(hex2), .HEX0(hex0),
        .BUSY(busy), .DONE(done), .PASS(pass),
        .ERR_COUNT(err_count), .FAIL_VEC(fail_vec)
    );

    function automatic logic [6:0] seg7(input int d);
        case (d)
            0: return 7'b1000000;  1: return 7'b1111001;
            2: return 7'b0100100;  3: return 7'b0110000;
            4: return 7'b0011001;  5: return 7'b0010010;
            6: return 7'b0000010;  7: return 7'b1111000;
            8: return 7'b0000000;  9: return 7'b0010000;
            default: return 7'b1010101;
        endcase
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Behavioural calculator with selectable faults.
    int ma, mb, mr;
    logic movf;
    always_comb begin
        ma = sw[7] ? int'(sw[7:4]) - 16 : int'(sw[7:4]);
        mb = sw[3] ? int'(sw[3:0]) - 16 : int'(sw[3:0]);
        case (key)
            3'd0: mr = ma + mb;
            3'd1: mr = mb + ma;
            3'd2: mr = ma - mb;
            3'd3: mr = mb - ma;
            3'd4: mr = iabs(ma);
            3'd5: mr = iabs(mb);
            default: mr = 0;
        endcase
        movf = (mr < -8) || (mr > 7);
        hex7 = (ma < 0) ? MINUS : BLANK;
        hex6 = seg7(iabs(ma));
        hex5 = (mb < 0) ? MINUS : BLANK;
        hex4 = seg7(iabs(mb));
        if (movf) begin
            hex3 = BLANK;
            hex2 = seg7(0);
            hex0 = SEG_E;
        end else begin
            hex3 = (mr < 0) ? MINUS : BLANK;
            hex2 = seg7(iabs(mr));
            hex0 = BLANK;
        end
        if (fault == 1 && key == 3'd0 && sw == 8'h71) hex0 = BLANK;
        if (fault == 2 && key == 3'd0 && sw == 8'hDE) hex3 = BLANK;
        if (fault == 2 && key == 3'd4 && sw == 8'h80) hex0 = BLANK;
        if (fault == 3 && movf) begin
            hex3 = 7'h55;
            hex2 = 7'h2A;
        end
        if (fault == 4) hex0 = 7'h00;
        if (fault == 5) hex5 = 7'h00;
    end

    task automatic chk(input string name, input int act, input int exp);
        applied++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    typedef struct {
        string      name;
        int         fault;
        int         poke1;
        int         poke2;
        int         exp_err;
        logic [10:0] exp_fail;
        logic       exp_pass;
    } vec_t;

    vec_t tbl[$];
    int cycles;

    // Start a sweep and count cycles from the START-sampling edge until DONE.
    task automatic run_sweep(input int p1, input int p2, output int n);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
        chk("done_cleared", int'(done), 0);
        n = 0;
        while (!done && n < 12000) begin
            start = (n == p1) || (n == p2);
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
    endtask

    initial begin
        tbl.push_back('{"clean",       0, -1,  -1,    0, 11'h7FF, 1'b1});
        tbl.push_back('{"no_e_7p1",    1, -1,  -1,    1, 11'h071, 1'b0});
        tbl.push_back('{"two_faults",  2, -1,  -1,    2, 11'h0DE, 1'b0});
        tbl.push_back('{"ovf_garbage", 3, -1,  -1,    0, 11'h7FF, 1'b1});
        tbl.push_back('{"start_busy",  0, 100, 9215,  0, 11'h7FF, 1'b1});
`ifdef CALC_CHECK_OPERANDS_EN
        tbl.push_back('{"stuck_hex5",  5, -1,  -1, 1536, 11'h000, 1'b0});
`endif

        // Reset state
        #12;
        chk("rst_key", int'(key), 0);
        chk("rst_sw", int'(sw), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pass", int'(pass), 0);
        chk("rst_err", int'(err_count), 0);
        chk("rst_fail", int'(fail_vec), 11'h7FF);
        @(negedge clk);
        rst_n = 1'b1;

        // Mid-sweep reset: every vector fails under fault 4, 83 checks done by cycle 500.
        fault = 4;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #1;
        end
        chk("mid_err", int'(err_count), 83);
        chk("mid_fail", int'(fail_vec), 11'h000);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_sw", int'(sw), 0);
        chk("abort_err", int'(err_count), 0);
        chk("abort_fail", int'(fail_vec), 11'h7FF);
        @(negedge clk);
        rst_n = 1'b1;

        for (int t = 0; t < tbl.size(); t++) begin
            fault = tbl[t].fault;
            run_sweep(tbl[t].poke1, tbl[t].poke2, cycles);
            chk({tbl[t].name, "_cycles"}, cycles, 9216);
            chk({tbl[t].name, "_err"}, int'(err_count), tbl[t].exp_err);
            chk({tbl[t].name, "_fail"}, int'(fail_vec), int'(tbl[t].exp_fail));
            chk({tbl[t].name, "_pass"}, int'(pass), int'(tbl[t].exp_pass));
            @(posedge clk); #1;
            chk({tbl[t].name, "_done_hold"}, int'(done), 1);
            chk({tbl[t].name, "_busy_low"}, int'(busy), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
